// File: rtl/game_pkg.sv
// Shared types and constants for the penalty shoot-out game logic.
// Holds the phase encoding, winner codes, output widths and small
// saturating-increment helpers used by penalty_round_ctl.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AIM     = 3'd1,
    RESOLVE = 3'd2,
    RESULT  = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5
  } phase_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int SCORE_W = 4;
  localparam int KICK_W  = 5;
  localparam int SEC_W   = 4;

  // Scores stop at 15 rather than wrapping back to 0.
  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // The kick counter stops at 31 rather than wrapping back to 0.
  function automatic logic [KICK_W-1:0] sat_inc_kick(input logic [KICK_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler. Divides the system clock by CLK_HZ and
// emits a single-cycle tick. A synchronous clear restarts the count,
// so the first tick after clear arrives exactly CLK_HZ cycles later.
module sec_tick_gen #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: hold at zero while cleared, wrap and tick on the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/penalty_round_ctl.sv
// Penalty shoot-out sequencer: kick order, aim countdown, goal/save
// resolution, scoring and end-of-match decision. Side A kicks first.
// Optional feature macro: SUDDEN_DEATH_EN. When defined, a tie after
// regulation continues in A/B pairs; otherwise such a tie is a draw.
module penalty_round_ctl
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 65_000_000,
  parameter int AIM_SEC   = 5,
  parameter int SHOW_CYC  = 65_000_000,
  parameter int REG_KICKS = 5,
  parameter int ZONES     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         shot_valid,
  input  logic [2:0]   shot_zone,
  input  logic         keep_valid,
  input  logic [2:0]   keep_zone,
  output phase_t       phase,
  output logic         shooter_b,
  output logic [4:0]   kick_cnt,
  output logic [3:0]   sec_left,
  output logic [3:0]   score_a,
  output logic [3:0]   score_b,
  output logic         goal_pulse,
  output logic         miss_pulse,
  output logic         match_over,
  output logic [1:0]   winner
);

  localparam logic [SEC_W-1:0] AIM_INIT  = SEC_W'(AIM_SEC);
  localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);
  localparam logic [3:0]       ZONE_LIM  = 4'(ZONES);
  localparam int               SHOW_W    = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);
  localparam logic [7:0]       REG8      = 8'(REG_KICKS);
  localparam logic [7:0]       REG_TOTAL = 8'(2 * REG_KICKS);

  phase_t              phase_q, phase_d;
  logic                shooter_q, shooter_d;
  logic [KICK_W-1:0]   kick_q, kick_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [SCORE_W-1:0]  score_a_q, score_a_d;
  logic [SCORE_W-1:0]  score_b_q, score_b_d;
  logic [1:0]          winner_q, winner_d;
  logic                shot_lat_q, shot_lat_d;
  logic [2:0]          shot_zone_q, shot_zone_d;
  logic                keep_lat_q, keep_lat_d;
  logic [2:0]          keep_zone_q, keep_zone_d;
  logic [SHOW_W-1:0]   show_q, show_d;

  logic       tick;
  logic       tick_clear;
  logic       shot_take, keep_take;
  logic       kick_goal;
  logic       end_match;
  logic [1:0] end_winner;
  logic [7:0] kick8, a_taken, b_taken, rem_a, rem_b, sa8, sb8;

  // The second counter only runs inside AIM, so each kick gets full seconds.
  assign tick_clear = (phase_q != AIM);

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  // A kick scores unless there was no shot or the keeper guessed the zone.
  assign kick_goal = shot_lat_q && (!keep_lat_q || (shot_zone_q != keep_zone_q));

  // Decide whether the match is over after the kick just completed.
  always_comb begin
    end_match  = 1'b0;
    end_winner = WIN_NONE;
    kick8      = {3'b000, kick_q};
    a_taken    = (kick8 + 8'd1) >> 1;
    b_taken    = kick8 >> 1;
    rem_a      = REG8 - a_taken;
    rem_b      = REG8 - b_taken;
    sa8        = {4'b0000, score_a_q};
    sb8        = {4'b0000, score_b_q};
    if (kick8 <= REG_TOTAL) begin
      if (sa8 > sb8 + rem_b) begin
        end_match  = 1'b1;
        end_winner = WIN_A;
      end else if (sb8 > sa8 + rem_a) begin
        end_match  = 1'b1;
        end_winner = WIN_B;
      end else if (kick8 == REG_TOTAL) begin
`ifdef SUDDEN_DEATH_EN
        end_match  = 1'b0;
`else
        end_match  = 1'b1;
        end_winner = WIN_DRAW;
`endif
      end
    end else begin
`ifdef SUDDEN_DEATH_EN
      if (!kick8[0] || (kick_q == '1)) begin
        if (sa8 > sb8) begin
          end_match  = 1'b1;
          end_winner = WIN_A;
        end else if (sb8 > sa8) begin
          end_match  = 1'b1;
          end_winner = WIN_B;
        end else if (kick_q == '1) begin
          end_match  = 1'b1;
          end_winner = WIN_DRAW;
        end
      end
`endif
    end
  end

  // Phase sequencing, choice latching, countdown and score updates.
  always_comb begin
    phase_d     = phase_q;
    shooter_d   = shooter_q;
    kick_d      = kick_q;
    sec_d       = sec_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    winner_d    = winner_q;
    shot_lat_d  = shot_lat_q;
    shot_zone_d = shot_zone_q;
    keep_lat_d  = keep_lat_q;
    keep_zone_d = keep_zone_q;
    show_d      = show_q;
    shot_take   = 1'b0;
    keep_take   = 1'b0;
    case (phase_q)
      IDLE, DONE: begin
        if (start) begin
          phase_d    = AIM;
          shooter_d  = 1'b0;
          kick_d     = '0;
          score_a_d  = '0;
          score_b_d  = '0;
          winner_d   = WIN_NONE;
          sec_d      = AIM_INIT;
          shot_lat_d = 1'b0;
          keep_lat_d = 1'b0;
        end
      end
      AIM: begin
        shot_take = shot_valid && !shot_lat_q && ({1'b0, shot_zone} < ZONE_LIM);
        keep_take = keep_valid && !keep_lat_q && ({1'b0, keep_zone} < ZONE_LIM);
        if (shot_take) begin
          shot_lat_d  = 1'b1;
          shot_zone_d = shot_zone;
        end
        if (keep_take) begin
          keep_lat_d  = 1'b1;
          keep_zone_d = keep_zone;
        end
        if ((shot_lat_d && keep_lat_d) || (tick && (sec_q == SEC_ONE))) begin
          phase_d = RESOLVE;
          sec_d   = '0;
        end else if (tick) begin
          sec_d = sec_q - SEC_ONE;
        end
      end
      RESOLVE: begin
        if (kick_goal) begin
          if (shooter_q) score_b_d = sat_inc_score(score_b_q);
          else           score_a_d = sat_inc_score(score_a_q);
        end
        kick_d  = sat_inc_kick(kick_q);
        show_d  = '0;
        phase_d = RESULT;
      end
      RESULT: begin
        if (show_q == SHOW_LAST) phase_d = CHECK;
        else                     show_d  = show_q + 1'b1;
      end
      CHECK: begin
        if (end_match) begin
          phase_d  = DONE;
          winner_d = end_winner;
        end else begin
          phase_d    = AIM;
          shooter_d  = ~shooter_q;
          sec_d      = AIM_INIT;
          shot_lat_d = 1'b0;
          keep_lat_d = 1'b0;
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  // Match state registers; reset returns everything to the idle screen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= IDLE;
      shooter_q   <= 1'b0;
      kick_q      <= '0;
      sec_q       <= '0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      winner_q    <= WIN_NONE;
      shot_lat_q  <= 1'b0;
      shot_zone_q <= '0;
      keep_lat_q  <= 1'b0;
      keep_zone_q <= '0;
      show_q      <= '0;
    end else begin
      phase_q     <= phase_d;
      shooter_q   <= shooter_d;
      kick_q      <= kick_d;
      sec_q       <= sec_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      winner_q    <= winner_d;
      shot_lat_q  <= shot_lat_d;
      shot_zone_q <= shot_zone_d;
      keep_lat_q  <= keep_lat_d;
      keep_zone_q <= keep_zone_d;
      show_q      <= show_d;
    end
  end

  assign phase      = phase_q;
  assign shooter_b  = shooter_q;
  assign kick_cnt   = kick_q;
  assign sec_left   = sec_q;
  assign score_a    = score_a_q;
  assign score_b    = score_b_q;
  assign winner     = winner_q;
  assign match_over = (phase_q == DONE);
  assign goal_pulse = (phase_q == RESOLVE) && kick_goal;
  assign miss_pulse = (phase_q == RESOLVE) && !kick_goal;

endmodule
